// File: rtl/spi_adc_responder.sv
// SPI mode-0 slave emulating a 12-bit ADC: serves a held sample on MISO and captures MOSI frames.
// Optional build macro TEST_RAMP_EN replaces the held sample with an internal counting ramp.
module spi_adc_responder #(
    parameter int DATA_W      = 12,
    parameter int FRAME_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  sample_data,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic               SCK,
    input  logic               CS,
    input  logic               MOSI,
    output logic               MISO,
    output logic               miso_oe,
    output logic [FRAME_W-1:0] rx_data,
    output logic               frame_done,
    output logic               frame_abort,
    output logic               sample_overrun,
    output logic               busy
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Pad synchronizers; one extra stage on SCK and CS gives the edge reference.
    // CS resets high so leaving reset never fakes a chip-select fall.
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_d, cs_d;
    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-1:0] rx_shift_q, rx_shift_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               miso_q, miso_d;
    logic               oe_q, oe_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic               overrun_q, overrun_d;
    logic [DATA_W-1:0]  tx_src;
    logic               load;

`ifdef TEST_RAMP_EN
    logic [DATA_W-1:0] ramp_q, ramp_d;
`else
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              pending_q, pending_d;
    logic              ready_q;
`endif

    assign load = (state_q == IDLE) && cs_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_q       <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef TEST_RAMP_EN
            ramp_q     <= '0;
`else
            hold_q     <= '0;
            pending_q  <= 1'b0;
            ready_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            overrun_q  <= overrun_d;
`ifdef TEST_RAMP_EN
            ramp_q     <= ramp_d;
`else
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            ready_q    <= 1'b1;
`endif
        end
    end

    // Sample source and holding register. A valid arriving in the same cycle as the
    // chip-select fall bypasses the holding register and is not an overrun.
    always_comb begin
        overrun_d = 1'b0;
`ifdef TEST_RAMP_EN
        tx_src = ramp_q;
        ramp_d = done_d ? ramp_q + DATA_W'(1) : ramp_q;
`else
        tx_src    = sample_valid ? sample_data : hold_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        if (sample_valid) begin
            hold_d    = sample_data;
            pending_d = 1'b1;
            if (pending_q && !load) overrun_d = 1'b1;
        end
        if (load) pending_d = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                oe_d   = 1'b0;
                if (cs_fall) begin
                    tx_d       = {{(FRAME_W-DATA_W){1'b0}}, tx_src};
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    miso_d     = tx_d[FRAME_W-1];
                    oe_d       = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT, DONE: begin
                // CS rise outranks any SCK edge seen in the same cycle.
                if (cs_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    oe_d    = 1'b0;
                    if (bit_cnt_q == CNT_W'(FRAME_W)) begin
                        rx_data_d = rx_shift_q;
                        done_d    = 1'b1;
                    end else begin
                        abort_d = 1'b1;
                    end
                end else if (state_q == SHIFT) begin
                    if (sck_rise) begin
                        rx_shift_d = {rx_shift_q[FRAME_W-2:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                            state_d = DONE;
                            miso_d  = 1'b0;
                        end
                    end else if (sck_fall) begin
                        tx_d   = tx_q << 1;
                        miso_d = tx_q[FRAME_W-2];
                    end
                end else begin
                    miso_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
                oe_d    = 1'b0;
            end
        endcase
    end

    assign MISO        = miso_q;
    assign miso_oe     = oe_q;
    assign rx_data     = rx_data_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign busy        = (state_q != IDLE);

`ifdef TEST_RAMP_EN
    assign sample_ready   = 1'b1;
    assign sample_overrun = 1'b0;
`else
    assign sample_ready   = ready_q;
    assign sample_overrun = overrun_q;
`endif

endmodule
